// File: rtl/audio_sample_player_pkg.sv
// Shared types and helpers for the audio sample player: FSM states,
// datapath widths and the linear interpolation between adjacent samples.
package audio_sample_player_pkg;

  localparam int unsigned FRAC_W   = 4;
  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned OUT_W    = 16;
  localparam int unsigned INTERP_W = 12;
  localparam int unsigned ACC_W    = 13;
  localparam int unsigned GAIN_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2
  } state_t;

  // cur*16 + (nxt-cur)*frac; always lands in 0..4080, so mod-2^13 math is exact
  function automatic logic [INTERP_W-1:0] interp_sample(
    input logic [SAMPLE_W-1:0] cur,
    input logic [SAMPLE_W-1:0] nxt,
    input logic [FRAC_W-1:0]   frac
  );
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] diff;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] sum;
    base = $signed({1'b0, cur, {FRAC_W{1'b0}}});
    diff = $signed(ACC_W'(nxt)) - $signed(ACC_W'(cur));
    prod = diff * $signed(ACC_W'(frac));
    sum  = base + prod;
    return sum[INTERP_W-1:0];
  endfunction

endpackage

// File: rtl/audio_rate_ticker.sv
// Reload down-counter: pulses tick_c for one clock every reload+1 enabled
// clocks; load presets the count without producing a tick.
module audio_rate_ticker #(
  parameter int unsigned RATE_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [RATE_W-1:0] reload,
  output logic              tick_c
);

  logic [RATE_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= reload;
    end else if (en) begin
      cnt <= (cnt == '0) ? reload : cnt - RATE_W'(1);
    end
  end

  assign tick_c = en && !load && (cnt == '0);

endmodule

// File: rtl/audio_sample_player.sv
// Sample ROM player: primes cur/next from the ROM, then interpolates 16
// sub-steps per sample at the programmed rate and scales by volume.
module audio_sample_player
  import audio_sample_player_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned LAST_ADDR = 255,
  parameter int unsigned RATE_W    = 12,
  parameter int unsigned ROM_LAT   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic [RATE_W-1:0]   rate_div,
  input  logic [3:0]          volume,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_data,
  output logic [OUT_W-1:0]    sample_out,
  output logic                sample_strobe,
  output logic                busy,
  output logic                done
);

  localparam int unsigned LAT_W = 3;
  localparam logic [LAT_W-1:0]  LAT_RELOAD = LAT_W'(ROM_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST       = ADDR_W'(LAST_ADDR);

  state_t                state, state_d;
  logic [ADDR_W-1:0]     rom_addr_d;
  logic [ADDR_W-1:0]     play_addr, play_addr_d;
  logic [SAMPLE_W-1:0]   cur, cur_d;
  logic [SAMPLE_W-1:0]   nxt, nxt_d;
  logic [FRAC_W-1:0]     frac, frac_d;
  logic [LAT_W-1:0]      lat_cnt, lat_d;
  logic                  fetch_pend, fetch_d;
  logic                  prime_ph, prime_ph_d;
  logic [OUT_W-1:0]      sample_d;
  logic                  strobe_d, busy_d, done_d;

  logic                  tick_c;
  logic                  load_c;
  logic [INTERP_W-1:0]   interp_c;
  logic [GAIN_W-1:0]     gain_c;
  logic [OUT_W-1:0]      scaled_c;
  logic [ADDR_W-1:0]     new_addr_c;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST) ? '0 : a + ADDR_W'(1);
  endfunction

  audio_rate_ticker #(.RATE_W(RATE_W)) u_ticker (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state == PLAY),
    .load   (load_c),
    .reload (rate_div),
    .tick_c (tick_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rom_addr      <= '0;
      play_addr     <= '0;
      cur           <= '0;
      nxt           <= '0;
      frac          <= '0;
      lat_cnt       <= '0;
      fetch_pend    <= 1'b0;
      prime_ph      <= 1'b0;
      sample_out    <= '0;
      sample_strobe <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_d;
      rom_addr      <= rom_addr_d;
      play_addr     <= play_addr_d;
      cur           <= cur_d;
      nxt           <= nxt_d;
      frac          <= frac_d;
      lat_cnt       <= lat_d;
      fetch_pend    <= fetch_d;
      prime_ph      <= prime_ph_d;
      sample_out    <= sample_d;
      sample_strobe <= strobe_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

  always_comb begin
    state_d     = state;
    rom_addr_d  = rom_addr;
    play_addr_d = play_addr;
    cur_d       = cur;
    nxt_d       = nxt;
    frac_d      = frac;
    lat_d       = lat_cnt;
    fetch_d     = fetch_pend;
    prime_ph_d  = prime_ph;
    sample_d    = sample_out;
    strobe_d    = 1'b0;
    done_d      = 1'b0;
    load_c      = 1'b0;
    interp_c    = interp_sample(cur, nxt, frac);
    gain_c      = {1'b0, volume} + GAIN_W'(1);
    scaled_c    = OUT_W'(interp_c) * OUT_W'(gain_c);
    new_addr_c  = next_addr(play_addr);

    if (stop) begin
      state_d = IDLE;
      fetch_d = 1'b0;
    end else if (start) begin
      state_d     = PRIME;
      rom_addr_d  = '0;
      play_addr_d = '0;
      lat_d       = LAT_RELOAD;
      prime_ph_d  = 1'b0;
      fetch_d     = 1'b0;
      frac_d      = '0;
    end else begin
      case (state)
        PRIME: begin
          if (lat_cnt != '0) begin
            lat_d = lat_cnt - LAT_W'(1);
          end else if (!prime_ph) begin
            cur_d      = rom_data;
            rom_addr_d = next_addr('0);
            lat_d      = LAT_RELOAD;
            prime_ph_d = 1'b1;
          end else begin
            // a one-entry one-shot table plays flat from the start
            nxt_d   = ((play_addr == LAST) && !loop_en) ? cur : rom_data;
            frac_d  = '0;
            load_c  = 1'b1;
            state_d = PLAY;
          end
        end
        PLAY: begin
          if (fetch_pend) begin
            if (lat_cnt != '0) begin
              lat_d = lat_cnt - LAT_W'(1);
            end else begin
              nxt_d   = rom_data;
              fetch_d = 1'b0;
            end
          end
          if (tick_c) begin
            sample_d = scaled_c;
            strobe_d = 1'b1;
            frac_d   = frac + FRAC_W'(1);
            if (frac == '1) begin
              if ((play_addr == LAST) && !loop_en) begin
                state_d = IDLE;
                done_d  = 1'b1;
                fetch_d = 1'b0;
              end else begin
                play_addr_d = new_addr_c;
                cur_d       = nxt;
                // last sample of a one-shot interpolates toward itself
                if ((new_addr_c == LAST) && !loop_en) begin
                  nxt_d   = nxt;
                  fetch_d = 1'b0;
                end else begin
                  rom_addr_d = next_addr(new_addr_c);
                  lat_d      = LAT_RELOAD;
                  fetch_d    = 1'b1;
                end
              end
            end
          end
        end
        IDLE:    ;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_audio_sample_player.sv
// Directed bench for audio_sample_player: one-shot, loop, volume, stop/start
// control and asynchronous reset against hand-derived sample values.
module tb_audio_sample_player;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned LAST_ADDR = 15;
  localparam int unsigned RATE_W    = 12;
  localparam int unsigned ROM_LAT   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [RATE_W-1:0] rate_div;
  logic [3:0]        volume;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [15:0]       sample_out;
  logic              sample_strobe;
  logic              busy;
  logic              done;

  logic [7:0] rom_mem [0:255];
  logic [7:0] rom_q;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;

  audio_sample_player #(
    .ADDR_W(ADDR_W), .LAST_ADDR(LAST_ADDR), .RATE_W(RATE_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .rate_div(rate_div), .volume(volume), .rom_addr(rom_addr), .rom_data(rom_data),
    .sample_out(sample_out), .sample_strobe(sample_strobe), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // one register stage after the array: data usable ROM_LAT=2 edges after the address
  always @(posedge clk) rom_q <= rom_mem[rom_addr];
  assign rom_data = rom_q;

  always @(posedge clk) begin
    if (sample_strobe) strobe_cnt <= strobe_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // rom[i] = 0x10*i up to 0x80, flat 0x80 to LAST: strobe n ramps n*256, then 0x8000
  function automatic logic [15:0] exp_ramp(input int n, input bit lp);
    int m;
    m = n % 256;
    if (m < 128) return 16'(m * 256);
    if (m < 240 || !lp) return 16'h8000;
    return 16'(32768 - (m - 240) * 2048);
  endfunction

  task automatic wait_strobe(input int budget, output bit got, output int gap);
    got = 1'b0;
    gap = 0;
    while (!got && gap < budget) begin
      @(negedge clk);
      gap++;
      if (sample_strobe) got = 1'b1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    rate_div = 12'd3; volume = 4'd15;
    repeat (3) @(negedge clk);
    checks++; if (sample_out !== 16'h0000) begin failures++; $display("FAIL reset_sample got=%h exp=0000", sample_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sample_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", sample_strobe); end
    checks++; if (rom_addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", rom_addr); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_one_shot();
    bit got;
    int gap;
    int s0;
    int d0;
    loop_en = 1'b0;
    d0 = done_cnt;
    pulse_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL os_busy_rise got=%b exp=1", busy); end
    for (int n = 0; n < 256; n++) begin
      wait_strobe(40, got, gap);
      checks++;
      if (!got) begin failures++; $display("FAIL os_strobe_timeout n=%0d got=none exp=strobe", n); break; end
      checks++;
      if (sample_out !== exp_ramp(n, 1'b0)) begin
        failures++; $display("FAIL os_value n=%0d got=%h exp=%h", n, sample_out, exp_ramp(n, 1'b0));
      end
      checks++;
      if (gap !== ((n == 0) ? 8 : 4)) begin
        failures++; $display("FAIL os_spacing n=%0d got=%0d exp=%0d", n, gap, (n == 0) ? 8 : 4);
      end
      if (n == 255) begin
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL os_done_pulse got=%b exp=1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL os_busy_drop got=%b exp=0", busy); end
      end
    end
    @(negedge clk);
    s0 = strobe_cnt;
    repeat (20) @(negedge clk);
    checks++; if (strobe_cnt !== s0) begin failures++; $display("FAIL os_no_more_strobes got=%0d exp=%0d", strobe_cnt, s0); end
    checks++; if (sample_out !== 16'h8000) begin failures++; $display("FAIL os_hold got=%h exp=8000", sample_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL os_idle_busy got=%b exp=0", busy); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL os_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_loop();
    bit got;
    int gap;
    int d0;
    loop_en = 1'b1;
    d0 = done_cnt;
    pulse_start();
    for (int n = 0; n < 272; n++) begin
      wait_strobe(40, got, gap);
      checks++;
      if (!got) begin failures++; $display("FAIL loop_strobe_timeout n=%0d got=none exp=strobe", n); break; end
      if (n >= 236) begin
        checks++;
        if (sample_out !== exp_ramp(n, 1'b1)) begin
          failures++; $display("FAIL loop_value n=%0d got=%h exp=%h", n, sample_out, exp_ramp(n, 1'b1));
        end
        checks++;
        if (gap !== 4) begin failures++; $display("FAIL loop_spacing n=%0d got=%0d exp=4", n, gap); end
      end
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL loop_busy got=%b exp=1", busy); end
    checks++; if (done_cnt !== d0) begin failures++; $display("FAIL loop_no_done got=%0d exp=%0d", done_cnt, d0); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    loop_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_volume();
    bit got;
    int gap;
    pulse_start();
    for (int n = 0; n < 130; n++) begin
      wait_strobe(40, got, gap);
      if (!got) begin
        checks++; failures++; $display("FAIL vol_strobe_timeout n=%0d got=none exp=strobe", n); break;
      end
    end
    checks++; if (sample_out !== 16'h8000) begin failures++; $display("FAIL vol_flat_full got=%h exp=8000", sample_out); end
    volume = 4'd0;
    for (int i = 0; i < 2; i++) begin
      wait_strobe(40, got, gap);
      checks++; if (sample_out !== 16'h0800) begin failures++; $display("FAIL vol_min i=%0d got=%h exp=0800", i, sample_out); end
      checks++; if (gap !== 4) begin failures++; $display("FAIL vol_spacing i=%0d got=%0d exp=4", i, gap); end
    end
    volume = 4'd7;
    wait_strobe(40, got, gap);
    checks++; if (sample_out !== 16'h4000) begin failures++; $display("FAIL vol_mid got=%h exp=4000", sample_out); end
    volume = 4'd15;
  endtask

  task automatic test_stop_start();
    bit got;
    int gap;
    int s0;
    int d0;
    logic [15:0] hold;
    hold = sample_out;
    d0 = done_cnt;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL stop_done got=%b exp=0", done); end
    @(negedge clk);
    s0 = strobe_cnt;
    repeat (16) @(negedge clk);
    checks++; if (strobe_cnt !== s0) begin failures++; $display("FAIL stop_strobes got=%0d exp=%0d", strobe_cnt, s0); end
    checks++; if (done_cnt !== d0) begin failures++; $display("FAIL stop_done_count got=%0d exp=%0d", done_cnt, d0); end
    checks++; if (sample_out !== hold) begin failures++; $display("FAIL stop_hold got=%h exp=%h", sample_out, hold); end
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL startstop_busy got=%b exp=0", busy); end
    repeat (16) @(negedge clk);
    checks++; if (strobe_cnt !== s0) begin failures++; $display("FAIL startstop_strobes got=%0d exp=%0d", strobe_cnt, s0); end
    pulse_start();
    for (int n = 0; n < 20; n++) begin
      wait_strobe(40, got, gap);
      if (!got) begin
        checks++; failures++; $display("FAIL restart_timeout n=%0d got=none exp=strobe", n); break;
      end
    end
    checks++; if (sample_out !== 16'h1300) begin failures++; $display("FAIL prerestart_value got=%h exp=1300", sample_out); end
    pulse_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL restart_busy got=%b exp=1", busy); end
    wait_strobe(40, got, gap);
    checks++; if (gap !== 8) begin failures++; $display("FAIL restart_latency got=%0d exp=8", gap); end
    checks++; if (sample_out !== 16'h0000) begin failures++; $display("FAIL restart_value got=%h exp=0000", sample_out); end
  endtask

  task automatic test_async_reset();
    bit got;
    int gap;
    int s0;
    pulse_start();
    for (int n = 0; n < 20; n++) begin
      wait_strobe(40, got, gap);
      if (!got) begin
        checks++; failures++; $display("FAIL ar_strobe_timeout n=%0d got=none exp=strobe", n); break;
      end
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sample_out !== 16'h0000) begin failures++; $display("FAIL ar_sample got=%h exp=0000", sample_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ar_busy got=%b exp=0", busy); end
    checks++; if (rom_addr !== 8'h00) begin failures++; $display("FAIL ar_addr got=%h exp=00", rom_addr); end
    checks++; if (sample_strobe !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL ar_pulses got=%b%b exp=00", sample_strobe, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s0 = strobe_cnt;
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ar_idle_busy got=%b exp=0", busy); end
    checks++; if (strobe_cnt !== s0) begin failures++; $display("FAIL ar_idle_strobes got=%0d exp=%0d", strobe_cnt, s0); end
    checks++; if (sample_out !== 16'h0000) begin failures++; $display("FAIL ar_idle_sample got=%h exp=0000", sample_out); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      if (i <= int'(LAST_ADDR)) rom_mem[i] = (i < 8) ? 8'(i * 16) : 8'h80;
      else rom_mem[i] = 8'hEE;
    end
    test_reset();
    test_one_shot();
    test_loop();
    test_volume();
    test_stop_start();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
